// File: rtl/rom_scanner_if.sv
// Bus between rom_scanner and its ROM/control neighbours.
// Carries target/match_cnt only when SCAN_MATCH_EN is defined.
interface rom_scanner_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic [ADDR_W+DATA_W-1:0] sum;
    logic [DATA_W-1:0]        max_val;
    logic [ADDR_W-1:0]        max_addr;
`ifdef SCAN_MATCH_EN
    logic [DATA_W-1:0]        target;
    logic [ADDR_W:0]          match_cnt;

    modport master (
        input  start, rom_data, target,
        output busy, done, rom_addr, sum, max_val, max_addr, match_cnt
    );
    modport slave (
        output start, rom_data, target,
        input  busy, done, rom_addr, sum, max_val, max_addr, match_cnt
    );
`else
    modport master (
        input  start, rom_data,
        output busy, done, rom_addr, sum, max_val, max_addr
    );
    modport slave (
        output start, rom_data,
        input  busy, done, rom_addr, sum, max_val, max_addr
    );
`endif
endinterface

// File: rtl/rom_scanner.sv
// Scans a synchronous-read ROM once per start, reducing it to sum/max/argmax.
// SCAN_MATCH_EN adds a count of entries equal to target.
module rom_scanner #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    rom_scanner_if.master bus
);
    localparam int SUM_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic              v;
    logic              v_d;
    logic [ADDR_W-1:0] a_d;
    logic [SUM_W-1:0]  data_ext;

    assign data_ext = {{ADDR_W{1'b0}}, bus.rom_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            v            <= 1'b0;
            v_d          <= 1'b0;
            a_d          <= '0;
            bus.rom_addr <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sum      <= '0;
            bus.max_val  <= '0;
            bus.max_addr <= '0;
`ifdef SCAN_MATCH_EN
            bus.match_cnt <= '0;
`endif
        end else begin
            v_d <= v;
            a_d <= bus.rom_addr;
            // v_d marks rom_data belonging to address a_d
            if (v_d) begin
                bus.sum <= bus.sum + data_ext;
                if (a_d == '0 || bus.rom_data > bus.max_val) begin
                    bus.max_val  <= bus.rom_data;
                    bus.max_addr <= a_d;
                end
`ifdef SCAN_MATCH_EN
                if (bus.rom_data == bus.target)
                    bus.match_cnt <= bus.match_cnt + 1'b1;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= ISSUE;
                        v            <= 1'b1;
                        bus.rom_addr <= '0;
                        bus.busy     <= 1'b1;
                        bus.sum      <= '0;
                        bus.max_val  <= '0;
                        bus.max_addr <= '0;
`ifdef SCAN_MATCH_EN
                        bus.match_cnt <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.rom_addr == LAST) begin
                        state <= DRAIN;
                        v     <= 1'b0;
                    end else begin
                        bus.rom_addr <= bus.rom_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (v_d && a_d == LAST) begin
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.rom_addr <= '0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_scanner.sv
// Bench for rom_scanner: ROM model plus array-based reference of scan results.
// Match checks are active when SCAN_MATCH_EN is defined.
module tb_rom_scanner;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] img [8];

    always #5 clk = ~clk;

    rom_scanner_if #(.ADDR_W(3), .DATA_W(4)) bus ();

    rom_scanner #(.ADDR_W(3), .DATA_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) bus.rom_data <= img[bus.rom_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(output int es, output int em, output int ea,
                         output int mc);
        es = 0; em = -1; ea = 0; mc = 0;
        for (int i = 0; i < 8; i++) begin
            es += int'(img[i]);
            if (int'(img[i]) > em) begin
                em = int'(img[i]);
                ea = i;
            end
`ifdef SCAN_MATCH_EN
            if (img[i] == bus.target) mc++;
`endif
        end
    endtask

    task automatic chk_results(input string tag, input int es, input int em,
                               input int ea, input int mc);
        chk({tag, "_sum"}, 32'(bus.sum), es);
        chk({tag, "_max"}, 32'(bus.max_val), em);
        chk({tag, "_maxaddr"}, 32'(bus.max_addr), ea);
`ifdef SCAN_MATCH_EN
        chk({tag, "_match"}, 32'(bus.match_cnt), mc);
`else
        if (mc != 0) chk({tag, "_match"}, mc, 0);
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(bus.rom_addr), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk_results(tag, 0, 0, 0, 0);
    endtask

    task automatic run_scan(input bit hammer);
        int es, em, ea, mc;
        model(es, em, ea, mc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k <= 7) chk("addr", 32'(bus.rom_addr), k);
            chk("busy", 32'(bus.busy), 32'(k <= 8));
            chk("done", 32'(bus.done), 32'(k == 9));
            bus.start = hammer && (k == 3 || k == 9);
            tick();
        end
        bus.start = 1'b0;
        chk_results("scan", es, em, ea, mc);
        for (int c = 0; c < 20; c++) begin
            chk("hold_done", 32'(bus.done), 0);
            tick();
        end
        chk_results("hold", es, em, ea, mc);
    endtask

    task automatic load_img1();
        logic [3:0] t [8];
        t = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3, 4'h6, 4'h9, 4'hC};
        for (int i = 0; i < 8; i++) img[i] = t[i];
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
`ifdef SCAN_MATCH_EN
        bus.target = 4'h6;
`endif
        load_img1();
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_zero("reset_idle");
            tick();
        end

        run_scan(1'b0);
`ifdef SCAN_MATCH_EN
        bus.target = 4'h7;
`endif
        run_scan(1'b0);

        for (int i = 0; i < 8; i++) img[i] = 4'hA;
`ifdef SCAN_MATCH_EN
        bus.target = 4'hA;
`endif
        run_scan(1'b0);

        load_img1();
        run_scan(1'b1);

        // abort mid-scan
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("abort");
        for (int c = 0; c < 12; c++) begin
            chk("abort_done", 32'(bus.done), 0);
            tick();
        end
        run_scan(1'b0);

        // start held: back-to-back scans 11 cycles apart
        bus.start = 1'b1;
        tick();
        for (int k = 0; k <= 21; k++) begin
            chk("b2b_done", 32'(bus.done), 32'(k == 9 || k == 20));
            if (k == 21) bus.start = 1'b0;
            tick();
        end
        repeat (12) tick();
        chk("b2b_idle", 32'(bus.busy), 0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 8; i++) img[i] = 4'($urandom_range(0, 15));
`ifdef SCAN_MATCH_EN
            bus.target = 4'($urandom_range(0, 15));
`endif
            run_scan(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
